seq_mul_8x8: RTL and testbench
==============================

SEQ_MUL_8X8 -- requirements
Module: seq_mul_8x8

Interface
REQ-001 The block SHALL have no parameters; operand width is fixed at 8 bits and product width at 16 bits.
REQ-002 clk  input  1  single clock; all state SHALL change on the rising edge only.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request to begin a multiply; sampled on the rising edge of clk.
REQ-005 a  input  8  multiplicand, unsigned; sampled together with start.
REQ-006 b  input  8  multiplier, unsigned; sampled together with start.
REQ-007 busy  output  1  high while a multiply is in progress (state RUN).
REQ-008 done  output  1  one-cycle pulse marking that product is valid.
REQ-009 product  output  16  unsigned a*b; driven directly from the accumulator register.

Function
REQ-010 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-011 IDLE->RUN SHALL occur on an edge with start=1; that edge SHALL load mcand={8'h00,a}, mplier=b, acc=0 and cnt=0.
REQ-012 In RUN, each edge SHALL do the following:
- if mplier[0]=1, set acc to the adder sum; otherwise leave acc unchanged;
- shift mcand left by 1;
- shift mplier right by 1 with zero fill;
- increment cnt.
REQ-013 RUN->DONE SHALL occur on the edge where cnt=7, so RUN lasts exactly 8 cycles regardless of operand values (no early exit when mplier=0).
REQ-014 DONE->IDLE SHALL occur unconditionally on the next edge.
REQ-015 done SHALL be 1 only in DONE and busy SHALL be 1 only in RUN; both are decoded from state register bits with no combinational path from inputs.
REQ-016 Latency: for start sampled at edge k, done SHALL be high during the cycle after edge k+8 (9 edges start-to-done).
REQ-017 product SHALL hold its value from DONE until the next accepted start clears acc.
REQ-018 start in RUN or DONE SHALL be ignored, with no capture of a/b and no restart.
REQ-019 start in the IDLE cycle directly after DONE SHALL be accepted, so back-to-back throughput is one result per 10 cycles.
REQ-020 The adder SHALL be driven with in_a=acc, in_b=mcand, cin=0.
REQ-021 No overflow can occur (max 255*255=65025 < 65536), so no carry-out handling is required.
REQ-022 a and b SHALL be don't-care outside the start-accept edge.

Reset
REQ-023 While rst=1, the block SHALL hold: state=IDLE, acc=0, mcand=0, mplier=0, cnt=0, busy=0, done=0, product=16'h0000.
REQ-024 Reset asserted mid-RUN or in DONE SHALL abort the operation immediately (asynchronously), with no done pulse.
REQ-025 After rst deasserts, the first edge SHALL be able to accept start.

Structure
REQ-026 A shared package SHALL define the state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the constant ITER=8.
REQ-027 The datapath adder SHALL be one instance of the existing 16-bit carry-lookahead adder, CLA_16bit; no behavioural "+" SHALL be used for acc.
REQ-028 cnt SHALL be 3 bits wide, and the FSM and datapath SHALL live in this single module.

Verification
REQ-029 a=13, b=11, start for 1 cycle -> busy high for 8 cycles, done pulse at edge k+9, product=143 (16'h008F).
REQ-030 a=255, b=255 -> product=65025 (16'hFE01); done pulse is exactly one cycle wide.
REQ-031 a=0, b=200 and a=200, b=0 -> product=0, same 9-edge latency in both cases.
REQ-032 a=7, b=9 accepted, then start with a=1, b=1 pulsed at RUN cycle 3 -> ignored; product=63.
REQ-033 rst pulsed at RUN cycle 4 of a=100, b=100 -> all outputs 0 immediately, no done; a new start with a=3, b=5 -> product=15.
REQ-034 Back-to-back: start held high continuously with random operands for 20 operations -> results match a*b, one done per 10 cycles.

Source files
------------

// File: rtl/seq_mul_8x8_pkg.sv
// Shared encodings and constants for the 8x8 sequential shift-add multiplier.
package seq_mul_8x8_pkg;

  localparam int OP_W   = 8;
  localparam int PROD_W = 16;
  localparam int ITER   = 8;

  // Counter value on which the final add/shift happens and RUN hands off to DONE.
  localparam logic [2:0] CNT_LAST = 3'(ITER - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/CLA_16bit.sv
// 16-bit carry-lookahead adder: four 4-bit lookahead groups joined by a
// second-level group lookahead unit, so no carry ripples across groups.
module CLA_16bit (
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  logic [15:0] g, p, c;
  logic [3:0]  gg, pg;
  logic [4:0]  cblk;

  assign g = in_a & in_b;
  assign p = in_a ^ in_b;

  // Per-group generate/propagate and in-group carries from the group carry-in.
  for (genvar j = 0; j < 4; j++) begin : g_grp
    localparam int B = 4 * j;
    assign gg[j] = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                 | (p[B+3] & p[B+2] & p[B+1] & g[B]);
    assign pg[j] = &p[B+3:B];
    assign c[B]   = cblk[j];
    assign c[B+1] = g[B] | (p[B] & cblk[j]);
    assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & cblk[j]);
    assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                  | (p[B+2] & p[B+1] & p[B] & cblk[j]);
  end

  // Second-level lookahead: group carry-ins straight from cin and group G/P.
  assign cblk[0] = cin;
  assign cblk[1] = gg[0] | (pg[0] & cin);
  assign cblk[2] = gg[1] | (pg[1] & gg[0]) | (pg[1] & pg[0] & cin);
  assign cblk[3] = gg[2] | (pg[2] & gg[1]) | (pg[2] & pg[1] & gg[0])
                 | (pg[2] & pg[1] & pg[0] & cin);
  assign cblk[4] = gg[3] | (pg[3] & gg[2]) | (pg[3] & pg[2] & gg[1])
                 | (pg[3] & pg[2] & pg[1] & gg[0]) | (pg[3] & pg[2] & pg[1] & pg[0] & cin);

  assign sum  = p ^ c;
  assign cout = cblk[4];

endmodule

// File: rtl/seq_mul_8x8.sv
// 8x8 unsigned shift-add multiplier: IDLE -> RUN (8 fixed iterations) -> DONE.
// Product is read straight off the accumulator and holds until the next start.
module seq_mul_8x8
  import seq_mul_8x8_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [OP_W-1:0]     a,
  input  logic [OP_W-1:0]     b,
  output logic                busy,
  output logic                done,
  output logic [PROD_W-1:0]   product
);

  state_e              state_q, state_d;
  logic [PROD_W-1:0]   acc_q, acc_d;
  logic [PROD_W-1:0]   mcand_q, mcand_d;
  logic [OP_W-1:0]     mplier_q, mplier_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [PROD_W-1:0]   sum;
  logic                cout_unused;

  // Accumulate step: acc + shifted multiplicand, carry-out can never be set.
  CLA_16bit u_add (
    .in_a (acc_q),
    .in_b (mcand_q),
    .cin  (1'b0),
    .sum  (sum),
    .cout (cout_unused)
  );

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next state and datapath update; RUN always takes ITER cycles, no early exit.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = RUN;
          mcand_d  = {8'h00, a};
          mplier_d = b;
          acc_d    = '0;
          cnt_d    = '0;
        end
      end
      RUN: begin
        if (mplier_q[0]) acc_d = sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 3'd1;
        if (cnt_q == CNT_LAST) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status decoded from the state register only, so no input-to-output path.
  assign busy    = (state_q == RUN);
  assign done    = (state_q == DONE);
  assign product = acc_q;

endmodule

// File: tb/tb_seq_mul_8x8.sv
// Bench for seq_mul_8x8: cycle-level reference model plus directed scenarios.
module tb_seq_mul_8x8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  a = 8'h00, b = 8'h00;
  logic        busy, done;
  logic [15:0] product;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  seq_mul_8x8 dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .product(product)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // m_t = edges since the accepting edge (0..8, 8 = result cycle), -1 = idle.
  int          m_t = -1;
  logic [7:0]  m_a = 8'h00, m_b = 8'h00;
  logic [15:0] m_hold = 16'h0000;
  logic [15:0] exp_q[$];

  // Value of a * (low t bits of b): what t shift-add iterations have summed.
  function automatic logic [15:0] partial(input logic [7:0] x, input logic [7:0] y, input int t);
    logic [7:0] m;
    m = (t >= 8) ? 8'hFF : 8'((1 << t) - 1);
    return 16'(x) * 16'(y & m);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_t    <= -1;
      m_hold <= 16'h0000;
    end else if (m_t < 0) begin
      if (start) begin
        m_t <= 0;
        m_a <= a;
        m_b <= b;
        exp_q.push_back(16'(a) * 16'(b));
      end
    end else if (m_t == 8) begin
      m_t    <= -1;
      m_hold <= partial(m_a, m_b, 8);
    end else begin
      m_t <= m_t + 1;
    end
  end

  logic [15:0] e_prod;
  logic        e_busy, e_done;
  always @(negedge clk) begin
    if (chk_en) begin
      e_busy = (m_t >= 0) && (m_t < 8);
      e_done = (m_t == 8);
      e_prod = (m_t < 0) ? m_hold : partial(m_a, m_b, m_t);
      chk("cyc_busy", 32'(busy), 32'(e_busy));
      chk("cyc_done", 32'(done), 32'(e_done));
      chk("cyc_product", 32'(product), 32'(e_prod));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic launch(input logic [7:0] ta, input logic [7:0] tb_, output int k);
    @(negedge clk);
    start = 1'b1; a = ta; b = tb_;
    @(negedge clk);
    k = cyc;
    start = 1'b0; a = 8'($urandom); b = 8'($urandom);
  endtask

  task automatic wait_done(input int k, output logic [15:0] p, output int lat, output int bn);
    bit found;
    found = 1'b0; bn = 0; p = 16'hFFFF; lat = -1;
    for (int i = 0; i < 20 && !found; i++) begin
      if (done) begin
        found = 1'b1; p = product; lat = cyc - k;
      end else begin
        if (busy) bn++;
        @(negedge clk);
      end
    end
    chk("done_seen", 32'(found), 32'd1);
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin : main
    int k, lat, bn, dn, last;
    logic [15:0] p;
    bit found;

    // Reset state, checked while rst is held.
    #1 rst = 1'b1;
    chk_en = 1'b1;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_product", 32'(product), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // 13*11: 8 busy cycles, done 8 edges after the accepting edge.
    launch(8'd13, 8'd11, k);
    wait_done(k, p, lat, bn);
    chk("p_13x11", 32'(p), 32'd143);
    chk("lat_13x11", 32'(lat), 32'd8);
    chk("busy_13x11", 32'(bn), 32'd8);
    @(negedge clk);
    chk("done_width_13x11", 32'(done), 32'd0);
    repeat (3) @(negedge clk);
    chk("hold_13x11", 32'(product), 32'h008F);

    // 255*255: largest product, single-cycle done.
    launch(8'd255, 8'd255, k);
    wait_done(k, p, lat, bn);
    chk("p_255x255", 32'(p), 32'hFE01);
    @(negedge clk);
    chk("done_width_255", 32'(done), 32'd0);

    // Zero operands: no early exit.
    launch(8'd0, 8'd200, k);
    wait_done(k, p, lat, bn);
    chk("p_0x200", 32'(p), 32'd0);
    chk("lat_0x200", 32'(lat), 32'd8);
    launch(8'd200, 8'd0, k);
    wait_done(k, p, lat, bn);
    chk("p_200x0", 32'(p), 32'd0);
    chk("lat_200x0", 32'(lat), 32'd8);

    // 7*9 with a stray start (1*1) during RUN: must be ignored.
    launch(8'd7, 8'd9, k);
    repeat (2) @(negedge clk);
    start = 1'b1; a = 8'd1; b = 8'd1;
    @(negedge clk);
    start = 1'b0;
    wait_done(k, p, lat, bn);
    chk("p_7x9", 32'(p), 32'd63);
    chk("lat_7x9", 32'(lat), 32'd8);
    repeat (3) @(negedge clk);
    chk("hold_7x9", 32'(product), 32'd63);
    chk("idle_busy_7x9", 32'(busy), 32'd0);

    // Async reset in the middle of RUN for 100*100.
    launch(8'd100, 8'd100, k);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_product", 32'(product), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    dn = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk("abort_no_done", 32'(dn), 32'd0);
    launch(8'd3, 8'd5, k);
    wait_done(k, p, lat, bn);
    chk("p_3x5", 32'(p), 32'd15);
    repeat (3) @(negedge clk);

    // Back-to-back: start held high, operands change every cycle.
    exp_q.delete();
    @(negedge clk);
    start = 1'b1; a = 8'($urandom); b = 8'($urandom);
    last = -1;
    for (int n = 0; n < 20; n++) begin
      found = 1'b0;
      for (int i = 0; i < 15 && !found; i++) begin
        @(negedge clk);
        a = 8'($urandom); b = 8'($urandom);
        if (done) found = 1'b1;
      end
      chk("b2b_done_seen", 32'(found), 32'd1);
      if (found) begin
        if (exp_q.size() > 0) chk("b2b_product", 32'(product), 32'(exp_q.pop_front()));
        else chk("b2b_queue_nonempty", 32'(exp_q.size()), 32'd1);
        if (last >= 0) chk("b2b_spacing", 32'(cyc - last), 32'd10);
        last = cyc;
      end
    end
    start = 1'b0;
    repeat (12) @(negedge clk);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
